// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - CPU MMIO register bus between a bus master and uart_rx_ctrl
interface uart_rx_ctrl_if;
  logic [1:0]  addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, we, re, wdata, input rdata);
  modport slave  (input addr, we, re, wdata, output rdata);
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - uart_rx byte capture FSM, receive FIFO and MMIO registers
// Define UART_RX_CTRL_IRQ_EN to add the irq_en/threshold fields and a registered irq output.
module uart_rx_ctrl #(
  parameter int          FIFO_AW      = 3,
  parameter logic [15:0] RESET_PERIOD = 16'd434
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_ctrl_if.slave   bus,
  input  logic [7:0]      rx_data,
  input  logic            rx_ready,
  output logic            rx_clear,
  output logic [15:0]     period,
  output logic            irq
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_WAIT, S_PUSH, S_CLEAR} state_e;

  state_e               state_q, state_d;
  logic [7:0]           mem_q [DEPTH];
  logic [7:0]           mem_d [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic                 enable_q, enable_d;
  logic [15:0]          period_q, period_d;
  logic                 empty, full, pop, push, ctrl_wr, flush;
  logic                 unused_wdata;

  assign unused_wdata = ^bus.wdata[31:16];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (rx_ready) state_d = S_PUSH;
      S_PUSH:  state_d = S_CLEAR;
      S_CLEAR: state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  assign rx_clear = (state_q == S_CLEAR);
  assign period   = period_q;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FULL_CNT);
    pop     = bus.re && (bus.addr == 2'd0) && !empty;
    // When full, a same-cycle pop frees the head slot, which is also the tail slot.
    push    = (state_q == S_PUSH) && enable_q && (!full || pop);
    ctrl_wr = bus.we && (bus.addr == 2'd3);
    flush   = ctrl_wr && bus.wdata[1];

    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    enable_d  = ctrl_wr ? bus.wdata[0] : enable_q;
    period_d  = period_q;

    if (push) mem_d[wr_ptr_q] = rx_data;

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      if (push && !pop)      count_d = count_q + (FIFO_AW + 1)'(1);
      else if (pop && !push) count_d = count_q - (FIFO_AW + 1)'(1);
      if ((state_q == S_PUSH) && enable_q && full && !pop) overrun_d = 1'b1;
    end

    if (bus.we && (bus.addr == 2'd2))
      period_d = (bus.wdata[15:0] == 16'd0) ? 16'd1 : bus.wdata[15:0];
  end

`ifdef UART_RX_CTRL_IRQ_EN
  logic       irq_en_q, irq_en_d;
  logic [2:0] thresh_q, thresh_d;
  logic       irq_q, irq_d;

  always_comb begin
    irq_en_d = ctrl_wr ? bus.wdata[2]   : irq_en_q;
    thresh_d = ctrl_wr ? bus.wdata[6:4] : thresh_q;
    irq_d    = irq_en_q && ((int'(count_q) > int'(thresh_q)) || overrun_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_WAIT;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      enable_q  <= 1'b1;
      period_q  <= RESET_PERIOD;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      enable_q  <= enable_d;
      period_q  <= period_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      2'd0: bus.rdata = empty ? 32'd0 : {24'd0, mem_q[rd_ptr_q]};
      2'd1: bus.rdata = {22'd0, overrun_q, full, empty, 3'b000, 4'(count_q)};
      2'd2: bus.rdata = {16'd0, period_q};
`ifdef UART_RX_CTRL_IRQ_EN
      2'd3: bus.rdata = {25'd0, thresh_q, 1'b0, irq_en_q, 1'b0, enable_q};
`else
      2'd3: bus.rdata = {31'd0, enable_q};
`endif
      default: bus.rdata = '0;
    endcase
  end
endmodule
